// File: rtl/bram_pkg.sv
// Shared helpers for the streamed dual-port BRAM: credit sizing, byte merge, config legality.
// Optional feature macro used by bram_stream_dp: BRAM_WRITE_FORWARD_EN.
package bram_pkg;

  localparam int unsigned MaxDataW = 512;
  localparam int unsigned MaxStrbW = MaxDataW / 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  function automatic int unsigned credit_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic logic [MaxDataW-1:0] byte_merge(
    input logic [MaxDataW-1:0] old_w,
    input logic [MaxDataW-1:0] new_w,
    input logic [MaxStrbW-1:0] strb
  );
    logic [MaxDataW-1:0] res;
    res = old_w;
    for (int i = 0; i < MaxStrbW; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  function automatic bit rsp_depth_ok(input int unsigned depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Per-port read response FIFO; entries live in flops so the head word is a registered output.
module bram_rsp_fifo
  import bram_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = credit_width(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [PW-1:0]                    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]                    count_q, count_d;
  logic                             pop, full;

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_i && !pop)      count_d = count_q + CW'(1);
    else if (!push_i && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Credits upstream make this unreachable; firing means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!rstn) !(push_i && full && !pop))
    else $error("bram_rsp_fifo overflow");

endmodule

// File: rtl/bram_stream_dp.sv
// True dual-port BRAM with valid/ready request and response streams, credit backpressure.
// Define BRAM_WRITE_FORWARD_EN to forward cross-port same-address writes into reads.
module bram_stream_dp
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_a_valid,
  output logic                  s_a_ready,
  input  logic                  s_a_we,
  input  logic [STRB_WIDTH-1:0] s_a_strb,
  input  logic [ADDR_WIDTH-1:0] s_a_addr,
  input  logic [DATA_WIDTH-1:0] s_a_wdata,
  output logic                  m_a_valid,
  input  logic                  m_a_ready,
  output logic [DATA_WIDTH-1:0] m_a_rdata,
  input  logic                  s_b_valid,
  output logic                  s_b_ready,
  input  logic                  s_b_we,
  input  logic [STRB_WIDTH-1:0] s_b_strb,
  input  logic [ADDR_WIDTH-1:0] s_b_addr,
  input  logic [DATA_WIDTH-1:0] s_b_wdata,
  output logic                  m_b_valid,
  input  logic                  m_b_ready,
  output logic [DATA_WIDTH-1:0] m_b_rdata
);

  localparam int unsigned CW    = credit_width(RSP_DEPTH);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("bram_stream_dp: RD_LATENCY must be 1..4");
  end
  if (!rsp_depth_ok(RSP_DEPTH)) begin : g_bad_depth
    $error("bram_stream_dp: RSP_DEPTH must be >= 1");
  end
  if ((DATA_WIDTH % 8 != 0) || (STRB_WIDTH != DATA_WIDTH / 8) || (DATA_WIDTH > MaxDataW)) begin : g_bad_width
    $error("bram_stream_dp: DATA_WIDTH must be a byte multiple matching STRB_WIDTH");
  end

  logic [1:0]                 req_valid, req_we, req_ready, rsp_valid, rsp_ready, rd_acc, wr_acc;
  logic [1:0][STRB_WIDTH-1:0] req_strb;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata, rsp_data;

  assign req_valid = {s_b_valid, s_a_valid};
  assign req_we    = {s_b_we, s_a_we};
  assign req_strb  = {s_b_strb, s_a_strb};
  assign req_addr  = {s_b_addr, s_a_addr};
  assign req_wdata = {s_b_wdata, s_a_wdata};
  assign rsp_ready = {m_b_ready, m_a_ready};

  assign s_a_ready = req_ready[0];
  assign s_b_ready = req_ready[1];
  assign m_a_valid = rsp_valid[0];
  assign m_b_valid = rsp_valid[1];
  assign m_a_rdata = rsp_data[0];
  assign m_b_rdata = rsp_data[1];

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Port b is written first so port a's strobed bytes land on top in a same-address collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wr_acc[1] && req_strb[1][i]) mem[req_addr[1]][i*8 +: 8] <= req_wdata[1][i*8 +: 8];
    end
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wr_acc[0] && req_strb[0][i]) mem[req_addr[0]][i*8 +: 8] <= req_wdata[0][i*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam int O = 1 - p;

    op_e                                op;
    logic                               accept, pop;
    logic [DATA_WIDTH-1:0]              rd_word;
    logic [RD_LATENCY-1:0]              vld_q;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;
    logic [CW-1:0]                      credit_q, credit_d;

    assign op           = req_we[p] ? OP_WRITE : OP_READ;
    assign req_ready[p] = rstn && (credit_q != '0);
    assign accept       = req_valid[p] && req_ready[p];
    assign rd_acc[p]    = accept && (op == OP_READ);
    assign wr_acc[p]    = accept && (op == OP_WRITE);
    assign pop          = rsp_valid[p] && rsp_ready[p];

`ifdef BRAM_WRITE_FORWARD_EN
    always_comb begin
      rd_word = mem[req_addr[p]];
      if (wr_acc[O] && (req_addr[O] == req_addr[p])) begin
        rd_word = DATA_WIDTH'(byte_merge(MaxDataW'(mem[req_addr[p]]), MaxDataW'(req_wdata[O]),
                                         MaxStrbW'(req_strb[O])));
      end
    end
`else
    assign rd_word = mem[req_addr[p]];
`endif

    always_comb begin
      credit_d = credit_q;
      if (rd_acc[p] && !pop)      credit_d = credit_q - CW'(1);
      else if (!rd_acc[p] && pop) credit_d = credit_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_q    <= '0;
        credit_q <= CW'(RSP_DEPTH);
      end else begin
        vld_q[0] <= rd_acc[p];
        for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        credit_q <= credit_d;
      end
    end

    // Data stages carry no reset; the valid tags alone decide what reaches the FIFO.
    always_ff @(posedge clk) begin
      if (rd_acc[p]) dat_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) dat_q[i] <= dat_q[i-1];
    end

    bram_rsp_fifo #(
      .DEPTH      (RSP_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .push_i      (vld_q[RD_LATENCY-1]),
      .push_data_i (dat_q[RD_LATENCY-1]),
      .valid_o     (rsp_valid[p]),
      .ready_i     (rsp_ready[p]),
      .data_o      (rsp_data[p])
    );
  end

endmodule

// File: tb/tb_bram_stream_dp.sv
// Scoreboard bench for bram_stream_dp (RD_LATENCY=2, RSP_DEPTH=4); honours BRAM_WRITE_FORWARD_EN.
module tb_bram_stream_dp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_a_valid = 0, s_a_we = 0, m_a_ready = 0;
  logic [3:0]  s_a_strb = '0;
  logic [9:0]  s_a_addr = '0;
  logic [31:0] s_a_wdata = '0;
  logic        s_b_valid = 0, s_b_we = 0, m_b_ready = 0;
  logic [3:0]  s_b_strb = '0;
  logic [9:0]  s_b_addr = '0;
  logic [31:0] s_b_wdata = '0;
  logic        s_a_ready, m_a_valid, s_b_ready, m_b_valid;
  logic [31:0] m_a_rdata, m_b_rdata;

  int checkCount = 0;
  int errorCount = 0;
  int stallCount = 0;
  logic [31:0] model [1024];
  logic [31:0] expA[$];
  logic [31:0] expB[$];

  bram_stream_dp #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .STRB_WIDTH(4), .RD_LATENCY(2), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_we(s_a_we), .s_a_strb(s_a_strb),
    .s_a_addr(s_a_addr), .s_a_wdata(s_a_wdata),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_rdata(m_a_rdata),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_we(s_b_we), .s_b_strb(s_b_strb),
    .s_b_addr(s_b_addr), .s_b_wdata(s_b_wdata),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_rdata(m_b_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = oldW;
    for (int i = 0; i < 4; i++) if (strb[i]) r[i*8 +: 8] = newW[i*8 +: 8];
    return r;
  endfunction

  // Response monitor: every pop is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (m_a_valid && m_a_ready) begin
        if (expA.size() == 0) checkOutput("a_unexpected_rsp", 32'(expA.size()), 32'd1);
        else checkOutput("a_rdata", m_a_rdata, expA.pop_front());
      end
      if (m_b_valid && m_b_ready) begin
        if (expB.size() == 0) checkOutput("b_unexpected_rsp", 32'(expB.size()), 32'd1);
        else checkOutput("b_rdata", m_b_rdata, expB.pop_front());
      end
    end
  end

  task automatic applyStimulus(
    input bit va, input bit wea, input logic [3:0] sa, input logic [9:0] aa, input logic [31:0] da,
    input bit vb, input bit web, input logic [3:0] sb, input logic [9:0] ab, input logic [31:0] db);
    int waits;
    logic [31:0] rdA, rdB;
    waits = 0;
    @(negedge clk);
    while ((va && !s_a_ready) || (vb && !s_b_ready)) begin
      waits++;
      stallCount++;
      if (waits > 100) begin
        checkOutput("ready_timeout", 32'(waits), 32'd0);
        return;
      end
      @(negedge clk);
    end
    s_a_valid = va; s_a_we = wea; s_a_strb = sa; s_a_addr = aa; s_a_wdata = da;
    s_b_valid = vb; s_b_we = web; s_b_strb = sb; s_b_addr = ab; s_b_wdata = db;
    rdA = model[aa];
    rdB = model[ab];
`ifdef BRAM_WRITE_FORWARD_EN
    if (vb && web && ab == aa) rdA = mergeBytes(rdA, db, sb);
    if (va && wea && aa == ab) rdB = mergeBytes(rdB, da, sa);
`endif
    if (va && !wea) expA.push_back(rdA);
    if (vb && !web) expB.push_back(rdB);
    if (vb && web) model[ab] = mergeBytes(model[ab], db, sb);
    if (va && wea) model[aa] = mergeBytes(model[aa], da, sa);
    @(posedge clk);
    #1;
    s_a_valid = 0;
    s_b_valid = 0;
  endtask

  task automatic setReady(input bit ra, input bit rb);
    @(posedge clk);
    #1;
    m_a_ready = ra;
    m_b_ready = rb;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expA.size() != 0 || expB.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checkOutput("drain_timeout", 32'(expA.size() + expB.size()), 32'd0);
        expA.delete();
        expB.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string phase);
    @(negedge clk);
    checkOutput({phase, "_m_a_valid"}, 32'(m_a_valid), 32'd0);
    checkOutput({phase, "_m_b_valid"}, 32'(m_b_valid), 32'd0);
    checkOutput({phase, "_m_a_rdata"}, m_a_rdata, 32'd0);
    checkOutput({phase, "_m_b_rdata"}, m_b_rdata, 32'd0);
    checkOutput({phase, "_s_a_ready"}, 32'(s_a_ready), 32'd0);
    checkOutput({phase, "_s_b_ready"}, 32'(s_b_ready), 32'd0);
  endtask

  initial begin
    int acc, lat, first, last, cnt, stallsBefore, seen;
    for (int i = 0; i < 1024; i++) model[i] = '0;

    checkResetOutputs("reset");
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(s_a_ready), 32'd1);

    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 4'hF, 10'(i), 32'hC0DE0000 | 32'(i), 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'hF, 10'd9, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4'hF, 10'd3, 32'hAAAAAAAA, 0, 0, 0, 0, 0);

    $display("[TB] write a / read b latency");
    setReady(1, 1);
    applyStimulus(1, 1, 4'hF, 10'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'h0, 10'd5, 0);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (m_b_valid) begin lat = n; break; end
    end
    checkOutput("b_latency", 32'(lat), 32'd3);
    waitDrain();

    $display("[TB] back-to-back reads on port a");
    first = -1; last = -1; cnt = 0;
    stallsBefore = stallCount;
    fork
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 10'(i), 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (m_a_valid) begin
          if (first < 0) first = c;
          last = c;
          cnt++;
        end
      end
    join
    checkOutput("b2b_count", 32'(cnt), 32'd8);
    checkOutput("b2b_span", 32'(last - first + 1), 32'd8);
    checkOutput("b2b_stalls", 32'(stallCount - stallsBefore), 32'd0);
    waitDrain();

    $display("[TB] backpressure on port a");
    for (int round = 0; round < 2; round++) begin
      setReady(0, 1);
      acc = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (s_a_ready) begin
          s_a_valid = 1; s_a_we = 0; s_a_addr = 10'(acc + 8 * round);
          expA.push_back(model[acc + 8 * round]);
          acc++;
        end
        @(posedge clk); #1;
        s_a_valid = 0;
      end
      checkOutput("bp_accepted", 32'(acc), 32'd4);
      @(negedge clk);
      checkOutput("bp_ready_low", 32'(s_a_ready), 32'd0);
      checkOutput("bp_valid_held", 32'(m_a_valid), 32'd1);
      checkOutput("bp_head_data", m_a_rdata, expA[0]);
      repeat (2) @(negedge clk);
      checkOutput("bp_head_stable", m_a_rdata, expA[0]);
      setReady(1, 1);
      waitDrain();
      checkOutput("bp_ready_restored", 32'(s_a_ready), 32'd1);
    end

    $display("[TB] same-address double write");
    applyStimulus(1, 1, 4'b0011, 10'd9, 32'h11111111, 1, 1, 4'b0110, 10'd9, 32'h22222222);
    applyStimulus(1, 0, 0, 10'd9, 0, 0, 0, 0, 0, 0);
    waitDrain();
    checkOutput("collision_model", model[9], 32'h00221111);

    $display("[TB] cross-port read during write");
    applyStimulus(1, 1, 4'hF, 10'd3, 32'h55555555, 1, 0, 0, 10'd3, 0);
`ifdef BRAM_WRITE_FORWARD_EN
    checkOutput("fwd_expect", expB[0], 32'h55555555);
`else
    checkOutput("rdfirst_expect", expB[0], 32'hAAAAAAAA);
`endif
    applyStimulus(1, 0, 0, 10'd4, 0, 1, 1, 4'b0101, 10'd4, 32'h99887766);
    applyStimulus(1, 0, 0, 10'd3, 0, 1, 0, 0, 10'd4, 0);
    waitDrain();

    $display("[TB] reset with reads in flight");
    applyStimulus(1, 0, 0, 10'd5, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 10'd6, 0, 0, 0, 0, 0, 0);
    rstn = 0;
    expA.delete();
    expB.delete();
    checkResetOutputs("midreset");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rstn = 1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_a_valid || m_b_valid) seen++;
    end
    checkOutput("no_rsp_after_reset", 32'(seen), 32'd0);
    applyStimulus(1, 0, 0, 10'd5, 0, 1, 0, 0, 10'd9, 0);
    waitDrain();

    checkOutput("queues_empty", 32'(expA.size() + expB.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
